// File: rtl/acc_core_mc.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM/HALT sequencing with req/ack
// instruction and data memory ports, relative branches and a retired counter.
module acc_core_mc #(
  parameter int unsigned DW   = 8,
  parameter int unsigned IW   = 9,
  parameter int unsigned NREG = 16,
  parameter int unsigned PCW  = 16,
  parameter int unsigned CW   = 16
) (
  input  logic           clk,
  input  logic           reset,
  output logic           im_req,
  output logic [PCW-1:0] im_addr,
  input  logic [IW-1:0]  im_rdata,
  input  logic           im_ack,
  output logic           dm_req,
  output logic           dm_we,
  output logic [DW-1:0]  dm_addr,
  output logic [DW-1:0]  dm_wdata,
  input  logic [DW-1:0]  dm_rdata,
  input  logic           dm_ack,
  output logic           done,
  output logic [CW-1:0]  retired
);

  localparam int unsigned FW   = IW - 4;
  localparam int unsigned PTRW = (NREG > 1) ? $clog2(NREG) : 1;

  if (PTRW > FW) begin : g_cfg_check
    $error("acc_core_mc: clog2(NREG) must not exceed IW-4");
  end

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_LDR = 4'h0, OP_STR, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SHL,
    OP_LDM, OP_STM, OP_BRZ, OP_BRN, OP_JMP
  } op_t;

  state_t          r_state;
  logic [PCW-1:0]  r_pc;
  logic [DW-1:0]   r_acc;
  logic            r_z;
  logic            r_neg;
  logic [DW-1:0]   r_rf [NREG];
  logic [IW-1:0]   r_ir;
  logic            r_done;
  logic [CW-1:0]   r_retired;

  op_t             w_op;
  logic [FW-1:0]   w_f;
  logic [PTRW-1:0] w_ptr;
  logic [DW-1:0]   w_imm;
  logic [PCW-1:0]  w_off;
  logic [DW-1:0]   w_rf_val;
  logic [DW-1:0]   w_alu;
  logic            w_acc_wr;
  logic            w_taken;

  assign w_op     = op_t'(r_ir[IW-1 -: 4]);
  assign w_f      = r_ir[FW-1:0];
  assign w_ptr    = w_f[PTRW-1:0];
  assign w_imm    = DW'(w_f);
  assign w_off    = PCW'($signed(w_f));
  assign w_rf_val = r_rf[w_ptr];

  always_comb begin
    w_alu    = r_acc;
    w_acc_wr = 1'b1;
    w_taken  = 1'b0;
    case (w_op)
      OP_LDR:  w_alu = w_rf_val;
      OP_LDI:  w_alu = w_imm;
      OP_ADD:  w_alu = r_acc + w_rf_val;
      OP_SUB:  w_alu = r_acc - w_rf_val;
      OP_AND:  w_alu = r_acc & w_rf_val;
      OP_XOR:  w_alu = r_acc ^ w_rf_val;
      OP_SHL:  w_alu = r_acc << 1;
      OP_BRZ:  begin w_acc_wr = 1'b0; w_taken = r_z;   end
      OP_BRN:  begin w_acc_wr = 1'b0; w_taken = r_neg; end
      OP_JMP:  begin w_acc_wr = 1'b0; w_taken = 1'b1;  end
      default: w_acc_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_acc     <= '0;
      r_z       <= 1'b1;
      r_neg     <= 1'b0;
      r_ir      <= '0;
      r_done    <= 1'b0;
      r_retired <= '0;
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (im_ack) begin
            r_ir    <= im_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_op == OP_LDM || w_op == OP_STM) begin
            r_state <= S_MEM;
          end else if (w_op == OP_JMP && w_f == '0) begin
            r_state   <= S_HALT;
            r_done    <= 1'b1;
            r_retired <= r_retired + CW'(1);
          end else begin
            if (w_acc_wr) begin
              r_acc <= w_alu;
              r_z   <= (w_alu == '0);
              r_neg <= w_alu[DW-1];
            end
            if (w_op == OP_STR) r_rf[w_ptr] <= r_acc;
            r_pc      <= w_taken ? r_pc + w_off : r_pc + PCW'(1);
            r_retired <= r_retired + CW'(1);
            r_state   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dm_ack) begin
            if (w_op == OP_LDM) begin
              r_acc <= dm_rdata;
              r_z   <= (dm_rdata == '0);
              r_neg <= dm_rdata[DW-1];
            end
            r_pc      <= r_pc + PCW'(1);
            r_retired <= r_retired + CW'(1);
            r_state   <= S_FETCH;
          end
        end
        S_HALT: ;
      endcase
    end
  end

  // Reset parks the FSM in FETCH, so the fetch request is masked by reset itself.
  assign im_req   = (r_state == S_FETCH) && reset;
  assign im_addr  = r_pc;
  assign dm_req   = (r_state == S_MEM);
  assign dm_we    = (w_op == OP_STM);
  assign dm_addr  = w_rf_val;
  assign dm_wdata = r_acc;
  assign done     = r_done;
  assign retired  = r_retired;

endmodule

// File: tb/tb_acc_core_mc.sv
// Bench for acc_core_mc: hand-computed program vectors, reset/wrap corner
// sequences, and random programs checked against an ISA-level model.
module tb_acc_core_mc;

  localparam logic [8:0] HLT = 9'h180;

  logic        clk, reset;
  logic        im_req, im_ack, dm_req, dm_we, dm_ack, done;
  logic [15:0] im_addr;
  logic [8:0]  im_rdata;
  logic [7:0]  dm_addr, dm_wdata, dm_rdata;
  logic [15:0] retired;

  acc_core_mc #(.DW(8), .IW(9), .NREG(16), .PCW(16), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .done(done), .retired(retired)
  );

  typedef struct { bit we; int addr; int data; } txn_t;
  typedef struct {
    int iw, dw, exp_cyc, exp_ret, nst, fa, fd, la, ld;
    logic [8:0] prog[24];
  } vec_t;

  logic [8:0] imem [256];
  logic [7:0] dmem [256];
  txn_t       log_q[$];
  txn_t       exp_q[$];
  vec_t       vecs[7];
  int         im_wait, dm_wait, im_cnt, dm_cnt;
  bit         noise_en;
  logic [15:0] hold_addr, last_fetch;
  logic [7:0]  hold_daddr, hold_wdata;
  int n_pass, n_tot;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [8:0] enc(input int op, input int f);
    logic [3:0] o;
    logic [4:0] ff;
    o = 4'(op);
    ff = 5'(f);
    return {o, ff};
  endfunction

  function automatic void p(input int v, input int a, input int op, input int f);
    vecs[v].prog[a] = enc(op, f);
  endfunction

  function automatic void hdr(input int v, input int iw, input int dw, input int cyc,
                              input int ret, input int nst, input int fa, input int fd,
                              input int la, input int ld);
    vecs[v].iw = iw; vecs[v].dw = dw; vecs[v].exp_cyc = cyc; vecs[v].exp_ret = ret;
    vecs[v].nst = nst; vecs[v].fa = fa; vecs[v].fd = fd; vecs[v].la = la; vecs[v].ld = ld;
    for (int a = 0; a < 24; a++) vecs[v].prog[a] = HLT;
  endfunction

  // Memory responders: configurable wait states, optional ack noise while idle.
  initial begin
    im_ack = 1'b0; im_rdata = '0; dm_ack = 1'b0; dm_rdata = '0;
    im_cnt = 0; dm_cnt = 0;
    forever begin
      @(negedge clk);
      if (im_req) begin
        if (im_cnt == 0) hold_addr = im_addr;
        else chk("im_addr_hold", im_addr, hold_addr);
        if (im_cnt >= im_wait) begin
          im_ack = 1'b1; im_rdata = imem[im_addr[7:0]]; last_fetch = im_addr;
        end else begin
          im_ack = 1'b0; im_rdata = 9'($urandom);
        end
        im_cnt++;
      end else begin
        im_cnt = 0; im_ack = noise_en ? 1'($urandom) : 1'b0; im_rdata = 9'($urandom);
      end
      if (dm_req) begin
        if (dm_cnt == 0) begin
          hold_daddr = dm_addr; hold_wdata = dm_wdata;
        end else begin
          chk("dm_addr_hold", dm_addr, hold_daddr);
          chk("dm_wdata_hold", dm_wdata, hold_wdata);
        end
        if (dm_cnt >= dm_wait) begin
          txn_t t;
          t.we = dm_we; t.addr = int'(dm_addr); t.data = dm_we ? int'(dm_wdata) : 0;
          log_q.push_back(t);
          dm_ack = 1'b1; dm_rdata = dmem[dm_addr];
          if (dm_we) dmem[dm_addr] = dm_wdata;
        end else begin
          dm_ack = 1'b0; dm_rdata = 8'($urandom);
        end
        dm_cnt++;
      end else begin
        dm_cnt = 0; dm_ack = noise_en ? 1'($urandom) : 1'b0; dm_rdata = 8'($urandom);
      end
    end
  end

  // ISA-level reference: executes the program word by word with plain arithmetic.
  task automatic model(input int iw, input int dw, output int ret, output int cyc);
    int rf[16];
    int mem[256];
    int acc, pc, npc, op, f, pr, off;
    bit z, n, wr;
    txn_t t;
    for (int i = 0; i < 256; i++) mem[i] = int'(dmem[i]);
    for (int i = 0; i < 16; i++) rf[i] = 0;
    acc = 0; z = 1; n = 0; pc = 0; ret = 0; cyc = 0;
    exp_q.delete();
    for (int step = 0; step < 2000; step++) begin
      op = int'(imem[pc % 256]) / 32;
      f = int'(imem[pc % 256]) % 32;
      pr = f % 16;
      off = (f >= 16) ? f - 32 : f;
      cyc += iw + 2;
      ret++;
      if (op == 12 && f == 0) break;
      wr = 0;
      npc = (pc + 1) % 65536;
      case (op)
        0: begin acc = rf[pr]; wr = 1; end
        1: rf[pr] = acc;
        2: begin acc = f; wr = 1; end
        3: begin acc = (acc + rf[pr]) % 256; wr = 1; end
        4: begin acc = (acc - rf[pr] + 256) % 256; wr = 1; end
        5: begin acc = acc & rf[pr]; wr = 1; end
        6: begin acc = acc ^ rf[pr]; wr = 1; end
        7: begin acc = (acc * 2) % 256; wr = 1; end
        8: begin
          cyc += dw + 1; t.we = 0; t.addr = rf[pr]; t.data = 0; exp_q.push_back(t);
          acc = mem[rf[pr]]; wr = 1;
        end
        9: begin
          cyc += dw + 1; t.we = 1; t.addr = rf[pr]; t.data = acc; exp_q.push_back(t);
          mem[rf[pr]] = acc;
        end
        10: if (z) npc = (pc + off + 65536) % 65536;
        11: if (n) npc = (pc + off + 65536) % 65536;
        12: npc = (pc + off + 65536) % 65536;
        default: ;
      endcase
      if (wr) begin z = (acc == 0); n = (acc >= 128); end
      pc = npc;
    end
  endtask

  task automatic run_prog(input int iw, input int dw, input bit nz, output int cyc);
    im_wait = iw; dm_wait = dw; noise_en = nz;
    log_q.delete();
    reset = 1'b0;
    #1;
    chk("rst_im_req", im_req, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_done", done, 0);
    chk("rst_retired", retired, 0);
    @(posedge clk); #2 reset = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); cyc++; #1;
    end while (!done && cyc < 5000);
    chk("halt_reached", done, 1);
  endtask

  initial begin
    int cyc, eret, ecyc, nst, fa, fd, la, ld, k, len;
    reset = 1'b0; n_pass = 0; n_tot = 0; noise_en = 0; im_wait = 0; dm_wait = 0;
    last_fetch = '0;
    for (int a = 0; a < 256; a++) dmem[a] = 8'($urandom);

    hdr(0, 0, 0, 8, 4, 0, 0, 0, 0, 0);
    p(0,0,2,5); p(0,1,1,1); p(0,2,3,1);
    hdr(1, 0, 0, 11, 5, 1, 5, 10, 5, 10);
    p(1,0,2,5); p(1,1,1,1); p(1,2,3,1); p(1,3,9,1);
    hdr(2, 3, 0, 10, 2, 0, 0, 0, 0, 0);
    p(2,0,2,7);
    hdr(3, 3, 0, 16, 3, 1, 0, 7, 0, 7);
    p(3,0,2,7); p(3,1,9,0);
    hdr(4, 0, 2, 45, 18, 2, 8'h40, 8'h9C, 0, 8'h9C);
    p(4,0,2,1); for (int a = 1; a <= 6; a++) p(4,a,7,0);
    p(4,7,1,2); p(4,8,7,0); p(4,9,1,3); p(4,10,2,28); p(4,11,6,3); p(4,12,9,2);
    p(4,13,2,0); p(4,14,8,2); p(4,15,11,2); p(4,17,9,0);
    hdr(5, 0, 0, 57, 28, 1, 0, 2, 0, 2);
    p(5,0,2,0); p(5,1,10,2); p(5,3,2,1); p(5,4,1,4); p(5,5,2,0); p(5,6,4,4);
    p(5,7,7,0); p(5,8,11,30); p(5,9,9,0);
    hdr(6, 0, 0, 41, 20, 1, 0, 8'h11, 0, 8'h11);
    p(6,0,2,1); p(6,1,1,1); p(6,2,2,0); p(6,3,4,1); p(6,4,3,1); p(6,5,10,2);
    p(6,7,11,2); p(6,8,2,1); for (int a = 9; a <= 16; a++) p(6,a,7,0);
    p(6,17,10,2); p(6,19,2,17); p(6,20,9,0);

    for (int v = 0; v < 7; v++) begin
      for (int a = 0; a < 256; a++) imem[a] = HLT;
      for (int a = 0; a < 24; a++) imem[a] = vecs[v].prog[a];
      run_prog(vecs[v].iw, vecs[v].dw, 1'b0, cyc);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_retired", v), retired, vecs[v].exp_ret);
      nst = 0; fa = -1; fd = -1; la = -1; ld = -1;
      foreach (log_q[i]) if (log_q[i].we) begin
        if (nst == 0) begin fa = log_q[i].addr; fd = log_q[i].data; end
        la = log_q[i].addr; ld = log_q[i].data; nst++;
      end
      chk($sformatf("v%0d_nstores", v), nst, vecs[v].nst);
      if (vecs[v].nst > 0) begin
        chk($sformatf("v%0d_first_addr", v), fa, vecs[v].fa);
        chk($sformatf("v%0d_first_data", v), fd, vecs[v].fd);
        chk($sformatf("v%0d_last_addr", v), la, vecs[v].la);
        chk($sformatf("v%0d_last_data", v), ld, vecs[v].ld);
      end
    end

    // Taken BRZ -1 at PC 0 (z=1 out of reset) wraps to the top of the PC space.
    for (int a = 0; a < 256; a++) imem[a] = HLT;
    imem[0] = enc(10, 31);
    run_prog(0, 0, 1'b0, cyc);
    chk("wrap_fetch_addr", last_fetch, 16'hFFFF);
    chk("wrap_retired", retired, 2);
    chk("wrap_cycles", cyc, 4);

    // Reset while a store sits in MEM: request drops without a clock edge.
    imem[0] = enc(2, 3); imem[1] = enc(9, 0);
    im_wait = 0; dm_wait = 1000; noise_en = 0; log_q.delete();
    reset = 1'b0; @(posedge clk); #2 reset = 1'b1;
    k = 0;
    while (!dm_req && k < 20) begin @(negedge clk); k++; end
    chk("abort_mem_req_seen", dm_req, 1);
    chk("abort_pre_retired", retired, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_dm_req", dm_req, 0);
    chk("abort_im_req", im_req, 0);
    chk("abort_retired", retired, 0);
    dm_wait = 0;
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk); #1;
    chk("restart_im_req", im_req, 1);
    chk("restart_pc", im_addr, 0);
    chk("restart_retired", retired, 0);
    k = 0;
    while (!done && k < 100) begin @(posedge clk); #1; k++; end
    chk("restart_done", done, 1);
    chk("restart_final_retired", retired, 3);
    chk("restart_nlog", log_q.size(), 1);
    if (log_q.size() == 1) chk("restart_store_data", log_q[0].data, 3);

    // Random forward-only programs against the ISA model, with ack noise.
    for (int r = 0; r < 40; r++) begin
      int iw, dw, op, f;
      iw = $urandom_range(0, 2); dw = $urandom_range(0, 2);
      len = $urandom_range(20, 31);
      for (int a = 0; a < 256; a++) begin imem[a] = HLT; dmem[a] = 8'($urandom); end
      for (int a = 0; a < len; a++) begin
        op = $urandom_range(0, 15); f = $urandom_range(0, 31);
        if (op >= 10 && op <= 12) f = $urandom_range(1, 3);
        imem[a] = enc(op, f);
      end
      imem[len] = enc(9, $urandom_range(0, 15));
      model(iw, dw, eret, ecyc);
      run_prog(iw, dw, 1'b1, cyc);
      chk($sformatf("rnd%0d_cycles", r), cyc, ecyc);
      chk($sformatf("rnd%0d_retired", r), retired, eret);
      chk($sformatf("rnd%0d_ntxn", r), log_q.size(), exp_q.size());
      if (log_q.size() == exp_q.size()) begin
        foreach (exp_q[i]) begin
          chk($sformatf("rnd%0d_txn%0d_we", r, i), log_q[i].we, exp_q[i].we);
          chk($sformatf("rnd%0d_txn%0d_addr", r, i), log_q[i].addr, exp_q[i].addr);
          chk($sformatf("rnd%0d_txn%0d_data", r, i), log_q[i].data, exp_q[i].data);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
